predictor_update_unit: RTL and testbench

- Resolves executed control-transfer instructions (CTIs) against the prediction made at fetch.
- Issues a registered misprediction redirect to the front end.
- Generates training writes (BHT/BTB/JTB) into the predictor update port through a small update FIFO.
- Sequences global predictor invalidation on fence: drain pending updates first, then pulse invalidate.

---
 rtl/predictor_update_unit.sv | 116 +++++++++++
 tb/tb_predictor_update_unit.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/predictor_update_unit.sv
// predictor_update_unit: CTI resolution, misprediction redirect, predictor training FIFO and fence invalidation (optional stats: PRED_UPD_STATS_EN)
module predictor_update_unit #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic        s_clk_i,
  input  logic        s_reset_i,
  input  logic        s_valid_i,
  input  logic        s_is_branch_i,
  input  logic        s_is_jal_i,
  input  logic        s_is_jalr_i,
  input  logic        s_rvc_i,
  input  logic        s_taken_i,
  input  logic [31:0] s_pc_i,
  input  logic [19:0] s_offset_i,
  input  logic [31:0] s_target_i,
  input  logic        s_pred_taken_i,
  input  logic [31:0] s_pred_add_i,
  input  logic        s_fence_i,
  input  logic        s_upd_ready_i,
  output logic        s_mispred_o,
  output logic [31:0] s_redirect_add_o,
  output logic        s_fence_busy_o,
  output logic        s_btb_update_o,
  output logic        s_branch_update_o,
  output logic        s_branch_taken_o,
  output logic        s_jump_update_o,
  output logic        s_instr_rvc_o,
  output logic [19:0] s_offset_o,
  output logic [31:0] s_base_add_o,
  output logic        s_invalidate_o
`ifdef PRED_UPD_STATS_EN
  ,
  output logic [CNT_W-1:0] s_cnt_cti_o,
  output logic [CNT_W-1:0] s_cnt_mispred_o,
  output logic [CNT_W-1:0] s_cnt_drop_o
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [1:0] IDLE = 2'd0, DRAIN = 2'd1, INV = 2'd2;
  logic [1:0] state;
  logic [56:0] mem [DEPTH];
  logic [AW:0] wr, rd;
  logic [56:0] head;
  logic [31:0] nxt;
  logic ne, mis, tkn, btb, jmp, enq, empty, full, pop, push;
  // resolve the executed instruction and decide what training it produces
  always_comb begin
    ne = s_pred_add_i != s_target_i;
    mis = s_is_branch_i ? (s_pred_taken_i != s_taken_i) | (s_pred_taken_i & s_taken_i & ne) :
          s_is_jal_i ? ~s_pred_taken_i | ne : s_pred_taken_i;
    tkn = s_is_branch_i ? s_taken_i : s_is_jal_i | s_is_jalr_i;
    nxt = tkn ? s_target_i : s_pc_i + (s_rvc_i ? 32'd2 : 32'd4);
    btb = s_is_branch_i & s_taken_i & (~s_pred_taken_i | ne);
    jmp = ~s_is_branch_i & s_is_jal_i & (~s_pred_taken_i | ne);
    enq = s_valid_i & (btb | s_is_branch_i | jmp);
    empty = wr == rd;
    full = (wr[AW] != rd[AW]) && (wr[AW-1:0] == rd[AW-1:0]);
    pop = ~empty & s_upd_ready_i & (state != INV);
    push = enq & (~full | pop);
    head = mem[rd[AW-1:0]];
  end
  assign s_btb_update_o = head[56] & pop;
  assign s_branch_update_o = head[55] & pop;
  assign s_branch_taken_o = head[54] & pop;
  assign s_jump_update_o = head[53] & pop;
  assign s_instr_rvc_o = head[52] & pop;
  assign s_offset_o = head[51:32];
  assign s_base_add_o = head[31:0];
  assign s_fence_busy_o = state != IDLE;
  assign s_invalidate_o = state == INV;
  // training FIFO: a push into a full FIFO only lands when the head leaves the same cycle
  always_ff @(posedge s_clk_i) begin
    if (s_reset_i) begin
      wr <= '0;
      rd <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr[AW-1:0]] <= {btb, s_is_branch_i, s_is_branch_i & s_taken_i, jmp, s_rvc_i, s_offset_i, s_pc_i};
        wr <= wr + 1'b1;
      end
      if (pop) rd <= rd + 1'b1;
    end
  end
  // one-cycle registered redirect strobe; address holds between mispredicts
  always_ff @(posedge s_clk_i) begin
    if (s_reset_i) begin
      s_mispred_o <= 1'b0;
      s_redirect_add_o <= '0;
    end else begin
      s_mispred_o <= s_valid_i & mis;
      s_redirect_add_o <= (s_valid_i & mis) ? nxt : s_redirect_add_o;
    end
  end
  // fence sequencing: drain queued training, then invalidate for one cycle
  always_ff @(posedge s_clk_i) begin
    if (s_reset_i) state <= IDLE;
    else state <= state == IDLE ? (s_fence_i ? DRAIN : IDLE) :
                  state == DRAIN ? (empty ? INV : DRAIN) : IDLE;
  end
`ifdef PRED_UPD_STATS_EN
  // saturating statistics counters
  always_ff @(posedge s_clk_i) begin
    if (s_reset_i) begin
      s_cnt_cti_o <= '0;
      s_cnt_mispred_o <= '0;
      s_cnt_drop_o <= '0;
    end else begin
      s_cnt_cti_o <= s_cnt_cti_o + CNT_W'(s_valid_i & (s_is_branch_i | s_is_jal_i | s_is_jalr_i) & ~&s_cnt_cti_o);
      s_cnt_mispred_o <= s_cnt_mispred_o + CNT_W'(s_valid_i & mis & ~&s_cnt_mispred_o);
      s_cnt_drop_o <= s_cnt_drop_o + CNT_W'(enq & full & ~pop & ~&s_cnt_drop_o);
    end
  end
`endif
endmodule

// File: tb/tb_predictor_update_unit.sv
// tb_predictor_update_unit: directed and random checks of predictor_update_unit against a queue-based reference
module tb_predictor_update_unit;
  localparam int DEPTH = 2;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, valid, is_br, is_jal, is_jalr, rvc, taken, pt, fence, rdy;
  logic [31:0] pc, tg, pa;
  logic [19:0] off;
  logic mispred, busy, btb_u, br_u, brt, jmp_u, rvc_o, inv;
  logic [31:0] redir, base;
  logic [19:0] off_o;
`ifdef PRED_UPD_STATS_EN
  logic [15:0] c_cti, c_mis, c_drop;
`endif
  predictor_update_unit #(.DEPTH(DEPTH), .CNT_W(16)) dut (
    .s_clk_i(clk), .s_reset_i(rst), .s_valid_i(valid), .s_is_branch_i(is_br),
    .s_is_jal_i(is_jal), .s_is_jalr_i(is_jalr), .s_rvc_i(rvc), .s_taken_i(taken),
    .s_pc_i(pc), .s_offset_i(off), .s_target_i(tg), .s_pred_taken_i(pt),
    .s_pred_add_i(pa), .s_fence_i(fence), .s_upd_ready_i(rdy),
    .s_mispred_o(mispred), .s_redirect_add_o(redir), .s_fence_busy_o(busy),
    .s_btb_update_o(btb_u), .s_branch_update_o(br_u), .s_branch_taken_o(brt),
    .s_jump_update_o(jmp_u), .s_instr_rvc_o(rvc_o), .s_offset_o(off_o),
    .s_base_add_o(base), .s_invalidate_o(inv)
`ifdef PRED_UPD_STATS_EN
    , .s_cnt_cti_o(c_cti), .s_cnt_mispred_o(c_mis), .s_cnt_drop_o(c_drop)
`endif
  );
  typedef struct packed {
    logic btb, br, brt, jmp, rvc;
    logic [19:0] off;
    logic [31:0] pc;
  } ent_t;
  ent_t q[$];
  int phase;
  int vec = 0, errs = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  // one clock: check combinational outputs against the model, then registered outputs after the edge
  task automatic tick();
    ent_t h, n;
    logic p, mis, tk, want;
    logic [31:0] addr;
    int sz;
    #1;
    sz = q.size();
    p = sz > 0 && rdy && phase != 2;
    h = sz > 0 ? q[0] : '0;
    chk("fence_busy", busy, phase != 0);
    chk("invalidate", inv, phase == 2);
    chk("btb_update", btb_u, p & h.btb);
    chk("branch_update", br_u, p & h.br);
    chk("branch_taken", brt, p & h.brt);
    chk("jump_update", jmp_u, p & h.jmp);
    chk("instr_rvc", rvc_o, p & h.rvc);
    if (p) begin
      chk("offset", off_o, h.off);
      chk("base_add", base, h.pc);
    end
    n = '0;
    n.rvc = rvc;
    n.off = off;
    n.pc = pc;
    if (is_br) begin
      tk = taken;
      mis = (pt != taken) || (pt && taken && pa != tg);
      n.br = 1'b1;
      n.brt = taken;
      n.btb = taken && (!pt || pa != tg);
    end else if (is_jal) begin
      tk = 1'b1;
      mis = !pt || pa != tg;
      n.jmp = mis;
    end else begin
      tk = is_jalr;
      mis = pt;
    end
    addr = tk ? tg : pc + (rvc ? 32'd2 : 32'd4);
    want = valid && (n.btb || n.br || n.jmp);
    @(posedge clk);
    #1;
    if (rst) begin
      q.delete();
      phase = 0;
      chk("rst_mispred", mispred, 0);
      chk("rst_redirect", redir, 0);
      chk("rst_busy", busy, 0);
      chk("rst_invalidate", inv, 0);
      chk("rst_btb_update", btb_u, 0);
    end else begin
      chk("mispred", mispred, valid && mis);
      if (valid && mis) chk("redirect", redir, addr);
      if (p) void'(q.pop_front());
      if (want && (sz < DEPTH || p)) q.push_back(n);
      if (phase == 0) phase = fence ? 1 : 0;
      else if (phase == 1) phase = sz == 0 ? 2 : 1;
      else phase = 0;
    end
  endtask
  task automatic cyc(input logic v, b, j, jr, c, t, input logic [31:0] ipc, itg,
                     input logic ipt, input logic [31:0] ipa, input logic f, r, rs);
    logic [31:0] d;
    @(negedge clk);
    valid = v; is_br = b; is_jal = j; is_jalr = jr; rvc = c; taken = t;
    pc = ipc; tg = itg; pt = ipt; pa = ipa; fence = f; rdy = r; rst = rs;
    d = itg - ipc;
    off = d[20:1];
    tick();
  endtask
  task automatic idle(input logic r);
    cyc(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 0, r, 0);
  endtask
  initial begin
    phase = 0;
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    cyc(1, 1, 0, 0, 0, 1, 32'h1000, 32'h1040, 0, 32'h0, 0, 1, 0);
    idle(1);
    cyc(1, 1, 0, 0, 1, 0, 32'h2002, 32'h2100, 1, 32'h2100, 0, 1, 0);
    idle(1);
    cyc(1, 0, 1, 0, 0, 1, 32'h3000, 32'h3100, 1, 32'h3100, 0, 1, 0);
    idle(1);
    cyc(1, 0, 0, 0, 0, 0, 32'h4000, 32'h4400, 1, 32'h4400, 0, 1, 0);
    cyc(1, 0, 0, 1, 0, 1, 32'h4800, 32'h5000, 1, 32'h0, 0, 1, 0);
    idle(1);
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0, 0, 1, 32'h6000 + 32'(i * 4), 32'h7000, 0, 0, 0, 0, 0);
    repeat (3) idle(1);
    for (int i = 0; i < 2; i++) cyc(1, 1, 0, 0, 0, 1, 32'h8000 + 32'(i * 4), 32'h8800, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    repeat (5) idle(1);
    for (int i = 0; i < 2; i++) cyc(1, 1, 0, 0, 0, 1, 32'h9000 + 32'(i * 4), 32'h9800, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    idle(0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    repeat (3) idle(1);
    for (int i = 0; i < 600; i++) begin
      int k;
      logic [31:0] rpc, rtg;
      k = int'($urandom_range(0, 3));
      rpc = $urandom & ~32'h1;
      rtg = $urandom & ~32'h1;
      cyc($urandom_range(0, 3) != 0, k == 0, k == 1, k == 2, 1'($urandom), 1'($urandom),
          rpc, rtg, 1'($urandom), $urandom_range(0, 1) != 0 ? rtg : ($urandom & ~32'h1),
          $urandom_range(0, 15) == 0, $urandom_range(0, 2) != 0, $urandom_range(0, 96) == 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
